// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response channel between the MEM stage and data memory.
// Request is valid/ready; response is valid-only.
interface mem_stage_ctrl_if #(
    parameter int unsigned DBITS = 32
);
    logic             dmem_req_valid;
    logic             dmem_req_we;
    logic [DBITS-1:0] dmem_req_addr;
    logic [DBITS-1:0] dmem_req_wdata;
    logic             dmem_req_ready;
    logic             dmem_resp_valid;
    logic [DBITS-1:0] dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: issues loads/stores to data memory, backpressures AGEX, drives MEM->WB.
// Optional response watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int unsigned DBITS          = 32,
    parameter int unsigned REGNOBITS      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 agex_valid,
    input  logic                 agex_is_load,
    input  logic                 agex_is_store,
    input  logic [DBITS-1:0]     agex_aluout,
    input  logic [DBITS-1:0]     agex_wr_val,
    input  logic [REGNOBITS-1:0] agex_rd,
    input  logic                 agex_wr_reg,
    input  logic [DBITS-1:0]     agex_pc,
    output logic                 agex_stall,
    mem_stage_ctrl_if.master     dmem,
    output logic                 wb_valid,
    output logic [REGNOBITS-1:0] wb_rd,
    output logic                 wb_wr_reg,
    output logic [DBITS-1:0]     wb_data,
    output logic [DBITS-1:0]     wb_pc,
    output logic                 fwd_busy,
    output logic [REGNOBITS-1:0] fwd_rd,
    output logic                 misalign_err
);

    if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [DBITS-1:0]       addr_q, addr_d;
    logic [DBITS-1:0]       wdata_q, wdata_d;
    logic [REGNOBITS-1:0]   rd_q, rd_d;
    logic                   wr_reg_q, wr_reg_d;
    logic [DBITS-1:0]       pc_q, pc_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [REGNOBITS-1:0]   wb_rd_q, wb_rd_d;
    logic                   wb_wr_reg_q, wb_wr_reg_d;
    logic [DBITS-1:0]       wb_data_q, wb_data_d;
    logic [DBITS-1:0]       wb_pc_q, wb_pc_d;
    logic                   misalign_q, misalign_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_reg_d    = wr_reg_q;
        pc_d        = pc_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_wr_reg_d = wb_wr_reg_q;
        wb_data_d   = wb_data_q;
        wb_pc_d     = wb_pc_q;
        misalign_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (agex_valid) begin
                    if (agex_is_load || agex_is_store) begin
                        if (agex_aluout[1:0] != 2'b00) begin
                            wb_valid_d  = 1'b1;
                            wb_wr_reg_d = 1'b0;
                            wb_rd_d     = agex_rd;
                            wb_data_d   = agex_aluout;
                            wb_pc_d     = agex_pc;
                            misalign_d  = 1'b1;
                        end else begin
                            we_d     = agex_is_store;
                            addr_d   = agex_aluout;
                            wdata_d  = agex_wr_val;
                            rd_d     = agex_rd;
                            wr_reg_d = agex_wr_reg;
                            pc_d     = agex_pc;
                            state_d  = StReq;
                        end
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = agex_rd;
                        wb_wr_reg_d = agex_wr_reg && (agex_rd != '0);
                        wb_data_d   = agex_aluout;
                        wb_pc_d     = agex_pc;
                    end
                end
            end
            StReq: begin
                // Response channel is ignored here even if it fires with ready.
                if (dmem.dmem_req_ready) begin
                    if (we_q) begin
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = rd_q;
                        wb_wr_reg_d = 1'b0;
                        wb_data_d   = addr_q;
                        wb_pc_d     = pc_q;
                        state_d     = StIdle;
                    end else begin
                        state_d = StResp;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            StResp: begin
                if (dmem.dmem_resp_valid) begin
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_wr_reg_d = wr_reg_q && (rd_q != '0);
                    wb_data_d   = dmem.dmem_resp_rdata;
                    wb_pc_d     = pc_q;
                    state_d     = StIdle;
                end
`ifdef MEM_TIMEOUT_EN
                // Counter holds the number of completed RESP cycles; fire on the last one.
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_wr_reg_d = 1'b0;
                    wb_data_d   = DBITS'(32'hDEADBEEF);
                    wb_pc_d     = pc_q;
                    misalign_d  = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            wr_reg_q    <= 1'b0;
            pc_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_reg_q <= 1'b0;
            wb_data_q   <= '0;
            wb_pc_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_reg_q    <= wr_reg_d;
            pc_q        <= pc_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_reg_q <= wb_wr_reg_d;
            wb_data_q   <= wb_data_d;
            wb_pc_q     <= wb_pc_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign agex_stall          = (state_q != StIdle);
    assign dmem.dmem_req_valid = (state_q == StReq);
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign fwd_busy            = (state_q == StResp);
    assign fwd_rd              = (state_q == StResp) ? rd_q : '0;
    assign wb_valid            = wb_valid_q;
    assign wb_rd               = wb_rd_q;
    assign wb_wr_reg           = wb_wr_reg_q;
    assign wb_data             = wb_data_q;
    assign wb_pc               = wb_pc_q;
    assign misalign_err        = misalign_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (timeout case runs when MEM_TIMEOUT_EN is defined).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        agex_valid, agex_is_load, agex_is_store, agex_wr_reg;
    logic [31:0] agex_aluout, agex_wr_val, agex_pc;
    logic [4:0]  agex_rd;
    logic        agex_stall;
    logic        wb_valid, wb_wr_reg, fwd_busy, misalign_err;
    logic [4:0]  wb_rd, fwd_rd;
    logic [31:0] wb_data, wb_pc;

    int nvec = 0;
    int nerr = 0;

    mem_stage_ctrl_if #(.DBITS(32)) dmem ();

    mem_stage_ctrl #(
        .DBITS(32),
        .REGNOBITS(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .agex_valid(agex_valid),
        .agex_is_load(agex_is_load),
        .agex_is_store(agex_is_store),
        .agex_aluout(agex_aluout),
        .agex_wr_val(agex_wr_val),
        .agex_rd(agex_rd),
        .agex_wr_reg(agex_wr_reg),
        .agex_pc(agex_pc),
        .agex_stall(agex_stall),
        .dmem(dmem.master),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_wr_reg(wb_wr_reg),
        .wb_data(wb_data),
        .wb_pc(wb_pc),
        .fwd_busy(fwd_busy),
        .fwd_rd(fwd_rd),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic ld, input logic st, input logic [31:0] addr,
                      input logic [31:0] wval, input logic [4:0] rd, input logic wr,
                      input logic [31:0] pc);
        agex_valid    = 1'b1;
        agex_is_load  = ld;
        agex_is_store = st;
        agex_aluout   = addr;
        agex_wr_val   = wval;
        agex_rd       = rd;
        agex_wr_reg   = wr;
        agex_pc       = pc;
    endtask

    initial begin
        reset = 1'b0;
        agex_valid = 0; agex_is_load = 0; agex_is_store = 0; agex_wr_reg = 0;
        agex_aluout = 0; agex_wr_val = 0; agex_pc = 0; agex_rd = 0;
        dmem.dmem_req_ready = 0; dmem.dmem_resp_valid = 0; dmem.dmem_resp_rdata = 0;
        tick(); tick();
        chk("rst_stall", agex_stall, 0);
        chk("rst_req_valid", dmem.dmem_req_valid, 0);
        chk("rst_req_addr", dmem.dmem_req_addr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fwd_busy", fwd_busy, 0);
        chk("rst_misalign", misalign_err, 0);
        reset = 1'b1;
        tick();

        // ALU op, latency 1
        op(0, 0, 32'h1234, 0, 5'd5, 1, 32'h40);
        chk("alu_stall_pre", agex_stall, 0);
        tick();
        agex_valid = 0;
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_wr_reg", wb_wr_reg, 1);
        chk("alu_wb_pc", wb_pc, 32'h40);
        chk("alu_stall", agex_stall, 0);
        tick();
        chk("alu_wb_pulse", wb_valid, 0);
        chk("alu_wb_hold", wb_data, 32'h1234);

        // ALU op to rd=0 never writes back
        op(0, 0, 32'h55, 0, 5'd0, 1, 32'h44);
        tick();
        agex_valid = 0;
        chk("rd0_wb_valid", wb_valid, 1);
        chk("rd0_wb_wr_reg", wb_wr_reg, 0);

        // SW with ready delayed 3 cycles; stray resp in REQ ignored
        op(0, 1, 32'h100, 32'hCAFEF00D, 5'd0, 0, 32'h48);
        tick();
        agex_valid = 0;
        for (int i = 0; i < 3; i++) begin
            dmem.dmem_resp_valid = (i == 1);
            chk("sw_req_valid", dmem.dmem_req_valid, 1);
            chk("sw_req_we", dmem.dmem_req_we, 1);
            chk("sw_req_addr", dmem.dmem_req_addr, 32'h100);
            chk("sw_req_wdata", dmem.dmem_req_wdata, 32'hCAFEF00D);
            chk("sw_stall", agex_stall, 1);
            chk("sw_wb_valid_wait", wb_valid, 0);
            tick();
        end
        dmem.dmem_resp_valid = 0;
        chk("sw_req_still", dmem.dmem_req_valid, 1);
        dmem.dmem_req_ready = 1;
        tick();
        dmem.dmem_req_ready = 0;
        chk("sw_wb_valid", wb_valid, 1);
        chk("sw_wb_wr_reg", wb_wr_reg, 0);
        chk("sw_req_drop", dmem.dmem_req_valid, 0);
        chk("sw_stall_done", agex_stall, 0);

        // LW: ready immediate with same-cycle resp (ignored), resp 2 cycles later
        op(1, 0, 32'h200, 0, 5'd7, 1, 32'h4C);
        tick();
        agex_valid = 0;
        chk("lw_req_valid", dmem.dmem_req_valid, 1);
        chk("lw_req_we", dmem.dmem_req_we, 0);
        chk("lw_req_addr", dmem.dmem_req_addr, 32'h200);
        dmem.dmem_req_ready = 1;
        dmem.dmem_resp_valid = 1;
        dmem.dmem_resp_rdata = 32'h11111111;
        tick();
        dmem.dmem_req_ready = 0;
        dmem.dmem_resp_valid = 0;
        chk("lw_resp_busy", fwd_busy, 1);
        chk("lw_resp_fwd_rd", fwd_rd, 7);
        chk("lw_resp_stall", agex_stall, 1);
        chk("lw_resp_no_wb", wb_valid, 0);
        chk("lw_req_drop", dmem.dmem_req_valid, 0);
        tick();
        chk("lw_resp_busy2", fwd_busy, 1);
        dmem.dmem_resp_valid = 1;
        dmem.dmem_resp_rdata = 32'hA5A5A5A5;
        tick();
        dmem.dmem_resp_valid = 0;
        chk("lw_wb_valid", wb_valid, 1);
        chk("lw_wb_data", wb_data, 32'hA5A5A5A5);
        chk("lw_wb_rd", wb_rd, 7);
        chk("lw_wb_wr_reg", wb_wr_reg, 1);
        chk("lw_wb_pc", wb_pc, 32'h4C);
        chk("lw_busy_done", fwd_busy, 0);
        chk("lw_stall_done", agex_stall, 0);

        // Misaligned LW
        op(1, 0, 32'h202, 0, 5'd3, 1, 32'h50);
        tick();
        agex_valid = 0;
        chk("mis_req_valid", dmem.dmem_req_valid, 0);
        chk("mis_err", misalign_err, 1);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_wr_reg", wb_wr_reg, 0);
        chk("mis_stall", agex_stall, 0);
        tick();
        chk("mis_err_pulse", misalign_err, 0);
        chk("mis_wb_pulse", wb_valid, 0);

        // Reset while in RESP, late response dropped
        op(1, 0, 32'h300, 0, 5'd9, 1, 32'h54);
        tick();
        agex_valid = 0;
        dmem.dmem_req_ready = 1;
        tick();
        dmem.dmem_req_ready = 0;
        chk("rr_busy", fwd_busy, 1);
        reset = 1'b0;
        #1;
        chk("rr_stall", agex_stall, 0);
        chk("rr_busy_clr", fwd_busy, 0);
        chk("rr_fwd_rd", fwd_rd, 0);
        chk("rr_wb_data", wb_data, 0);
        chk("rr_wb_rd", wb_rd, 0);
        chk("rr_req_addr", dmem.dmem_req_addr, 0);
        dmem.dmem_resp_valid = 1;
        dmem.dmem_resp_rdata = 32'h77;
        tick();
        reset = 1'b1;
        tick();
        chk("rr_no_wb1", wb_valid, 0);
        tick();
        dmem.dmem_resp_valid = 0;
        chk("rr_no_wb2", wb_valid, 0);
        chk("rr_wb_data2", wb_data, 0);

`ifdef MEM_TIMEOUT_EN
        // LW with no response times out after 4 RESP cycles
        op(1, 0, 32'h400, 0, 5'd4, 1, 32'h58);
        tick();
        agex_valid = 0;
        dmem.dmem_req_ready = 1;
        tick();
        dmem.dmem_req_ready = 0;
        chk("to_busy0", fwd_busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_wb", wb_valid, 0);
            chk("to_wait_busy", fwd_busy, 1);
        end
        tick();
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_data", wb_data, 32'hDEADBEEF);
        chk("to_wb_wr_reg", wb_wr_reg, 0);
        chk("to_err", misalign_err, 1);
        chk("to_stall", agex_stall, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
